// File: rtl/vga_sig_gen_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_sig_gen_param
//   Parametrised VGA timing and pixel generator. A divider derives a pixel
//   tick from CLK. Free-running H/V counters produce the sync pulses and a
//   down-scaled frame-buffer read address. The 1-bit frame-buffer data is
//   mapped onto a foreground/background colour pair. The pair is re-latched
//   only at the top of each frame, so a frame never tears. The sync and
//   visible qualifiers are delayed to match the frame-buffer read latency.
//   This keeps sync and colour aligned with the returned pixel data.
//
// Ports
//   CLK             in   system clock
//   RESETN          in   asynchronous active-low reset
//   EN              in   1 = generate video, 0 = hold reset state (synchronous)
//   CONFIG_COLOURS  in   {foreground, background} colour pair
//   DPR_CLK         out  pixel-rate clock for the frame-buffer read port
//   VGA_ADDR        out  {row, col} frame-buffer read address
//   VGA_DATA        in   frame-buffer pixel bit (1 = foreground)
//   VGA_HS          out  horizontal sync, active level HS_POL
//   VGA_VS          out  vertical sync, active level VS_POL
//   VGA_COLOUR      out  pixel colour, 0 while blanking
//   FRAME_START     out  one-CLK pulse on the tick where H=0,V=0
// -----------------------------------------------------------------------------
module vga_sig_gen_param #(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int ADDR_SCALE = 2,
  parameter int ADDR_X_W   = 8,
  parameter int ADDR_Y_W   = 7,
  parameter int DATA_LAT   = 1,
  parameter int COLOUR_W   = 8
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         EN,
  input  logic [2*COLOUR_W-1:0]        CONFIG_COLOURS,
  output logic                         DPR_CLK,
  output logic [ADDR_Y_W+ADDR_X_W-1:0] VGA_ADDR,
  input  logic                         VGA_DATA,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic [COLOUR_W-1:0]          VGA_COLOUR,
  output logic                         FRAME_START
);

  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // +1 so that the sync-end bound (which may equal HT/VT) also fits.
  localparam int H_CNT_W = $clog2(HT + 1);
  localparam int V_CNT_W = $clog2(VT + 1);

  // Counters are widened if needed so the address slice is always in range.
  localparam int H_W = (H_CNT_W > ADDR_SCALE + ADDR_X_W) ? H_CNT_W : ADDR_SCALE + ADDR_X_W;
  localparam int V_W = (V_CNT_W > ADDR_SCALE + ADDR_Y_W) ? V_CNT_W : ADDR_SCALE + ADDR_Y_W;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [H_W-1:0] H_LAST    = H_W'(HT - 1);
  localparam logic [H_W-1:0] H_VIS_END = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] H_SYNC_LO = H_W'(H_VISIBLE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_HI = H_W'(H_VISIBLE + H_FP + H_SYNC);

  localparam logic [V_W-1:0] V_LAST    = V_W'(VT - 1);
  localparam logic [V_W-1:0] V_VIS_END = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] V_SYNC_LO = V_W'(V_VISIBLE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_HI = V_W'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  // ---------------------------------------------------------------------------
  // Pixel-tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;
  logic             tick;

  assign tick    = EN && (div_q == DIV_LAST);
  assign div_nxt = tick ? '0 : div_q + DIV_W'(1);

  // DPR_CLK is registered from the next divider value rather than decoded
  // from div_q afterwards. It therefore equals (div >= CLK_DIV/2) without
  // any decode glitch reaching the frame-buffer clock pin.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_q   <= '0;
      DPR_CLK <= 1'b0;
    end else if (!EN) begin
      div_q   <= '0;
      DPR_CLK <= 1'b0;
    end else begin
      div_q   <= div_nxt;
      DPR_CLK <= (div_nxt >= DIV_HALF);
    end
  end

  // ---------------------------------------------------------------------------
  // Timing counters
  // ---------------------------------------------------------------------------
  logic [H_W-1:0] h_q;
  logic [V_W-1:0] v_q;
  logic           h_wrap;
  logic           v_wrap;
  logic           frame_pos;

  assign h_wrap    = (h_q == H_LAST);
  assign v_wrap    = (v_q == V_LAST);
  assign frame_pos = (h_q == '0) && (v_q == '0);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!EN) begin
      h_q <= '0;
      v_q <= '0;
    end else if (tick) begin
      h_q <= h_wrap ? '0 : h_q + H_W'(1);
      if (h_wrap) begin
        v_q <= v_wrap ? '0 : v_q + V_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Raw qualifiers for the current counter position
  // ---------------------------------------------------------------------------
  logic vis_raw;
  logic hs_raw;
  logic vs_raw;

  assign vis_raw = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign hs_raw  = (h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI);
  assign vs_raw  = (v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI);

  // ---------------------------------------------------------------------------
  // Latency delay line: qualifiers travel DATA_LAT ticks so that they meet the
  // VGA_DATA returned for the address issued on the same tick.
  // ---------------------------------------------------------------------------
  logic vis_d;
  logic hs_d;
  logic vs_d;

  if (DATA_LAT == 0) begin : g_no_lat
    assign vis_d = vis_raw;
    assign hs_d  = hs_raw;
    assign vs_d  = vs_raw;
  end else begin : g_lat
    // Each stage holds {vis, hs, vs}.
    logic [2:0] qual_sr [DATA_LAT];

    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        for (int i = 0; i < DATA_LAT; i++) qual_sr[i] <= 3'b000;
      end else if (!EN) begin
        for (int i = 0; i < DATA_LAT; i++) qual_sr[i] <= 3'b000;
      end else if (tick) begin
        qual_sr[0] <= {vis_raw, hs_raw, vs_raw};
        for (int i = 1; i < DATA_LAT; i++) qual_sr[i] <= qual_sr[i-1];
      end
    end

    assign {vis_d, hs_d, vs_d} = qual_sr[DATA_LAT-1];
  end

  // ---------------------------------------------------------------------------
  // Colour pair latch
  //   This latch has no asynchronous reset because it must follow
  //   CONFIG_COLOURS while the block is idle. An asynchronous load of a data
  //   value is not a clean construct. Each frame begins with a reload on the
  //   H=0,V=0 tick, so the value that reaches the screen is always well defined.
  // ---------------------------------------------------------------------------
  logic [COLOUR_W-1:0] fg_q;
  logic [COLOUR_W-1:0] bg_q;

  always_ff @(posedge CLK) begin
    if (!RESETN || !EN || (tick && frame_pos)) begin
      {fg_q, bg_q} <= CONFIG_COLOURS;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. All of them update only on tick edges, apart from the
  // reset/disable state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      VGA_ADDR    <= '0;
      VGA_COLOUR  <= '0;
      VGA_HS      <= ~HS_ACT;
      VGA_VS      <= ~VS_ACT;
      FRAME_START <= 1'b0;
    end else if (!EN) begin
      VGA_ADDR    <= '0;
      VGA_COLOUR  <= '0;
      VGA_HS      <= ~HS_ACT;
      VGA_VS      <= ~VS_ACT;
      FRAME_START <= 1'b0;
    end else begin
      // Ticks are at least two CLKs apart, so this is a single-CLK pulse.
      FRAME_START <= tick && frame_pos;
      if (tick) begin
        // The address is also produced in blanking. The truncated bits there
        // select don't-care data.
        VGA_ADDR   <= {v_q[ADDR_SCALE +: ADDR_Y_W], h_q[ADDR_SCALE +: ADDR_X_W]};
        VGA_COLOUR <= vis_d ? (VGA_DATA ? fg_q : bg_q) : '0;
        VGA_HS     <= hs_d ? HS_ACT : ~HS_ACT;
        VGA_VS     <= vs_d ? VS_ACT : ~VS_ACT;
      end
    end
  end

endmodule
